// File: rtl/sell_arbiter.sv
// Round-robin arbiter/sequencer sharing one ticket-sell fare engine among N_KIOSK kiosks.
// The winner's trip is latched at grant and only the winner's coins reach the engine.
module sell_arbiter #(
    parameter int N_KIOSK = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_KIOSK-1:0]     req,
    input  logic [3*N_KIOSK-1:0]   req_origin,
    input  logic [3*N_KIOSK-1:0]   req_dest,
    input  logic [3*N_KIOSK-1:0]   req_count,
    input  logic [N_KIOSK-1:0]     coin_valid,
    input  logic [6*N_KIOSK-1:0]   coin_value,
    input  logic                   eng_done,
    input  logic [7:0]             eng_change,
    output logic                   eng_start,
    output logic [2:0]             eng_origin,
    output logic [2:0]             eng_dest,
    output logic [2:0]             eng_count,
    output logic                   eng_coin_valid,
    output logic [5:0]             eng_coin_value,
    output logic                   eng_abort,
    output logic [N_KIOSK-1:0]     grant,
    output logic                   busy,
    output logic [N_KIOSK-1:0]     done_pulse,
    output logic [7:0]             change_out,
    output logic [N_KIOSK-1:0]     reject,
    output logic                   timeout_err
);
    localparam int IW = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_PAY    = 3'd2,
        S_FINISH = 3'd3,
        S_ABORT  = 3'd4,
        S_REJECT = 3'd5
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          last_q, win_q;
    logic [7:0]             timer_q, timer_d;
    logic [2:0]             origin_q, dest_q, count_q;
    logic [N_KIOSK-1:0]     grant_q, done_pulse_q, reject_q;
    logic                   busy_q, eng_start_q, eng_abort_q, timeout_err_q;
    logic [7:0]             change_out_q;

    logic [N_KIOSK-1:0][2:0] org_v, dst_v, cnt_v;
    logic [N_KIOSK-1:0][5:0] coin_v;
    assign org_v  = req_origin;
    assign dst_v  = req_dest;
    assign cnt_v  = req_count;
    assign coin_v = coin_value;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          pick_bad;
    logic          win_coin;
    logic          in_pay;

    // Search begins one past the previous winner, wrapping modulo N_KIOSK.
    always_comb begin
        int j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int i = 1; i <= N_KIOSK; i++) begin
            j = int'(last_q) + i;
            if (j >= N_KIOSK) j = j - N_KIOSK;
            if (!pick_found && req[j]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    assign pick_bad = (org_v[pick_idx] == dst_v[pick_idx]) || (cnt_v[pick_idx] == 3'd0);

    assign in_pay   = (state_q == S_PAY);
    assign win_coin = coin_valid[win_q];

    assign eng_coin_valid = in_pay && win_coin;
    assign eng_coin_value = in_pay ? coin_v[win_q] : 6'd0;

    // Next timer value; the timeout test compares against it so the abort
    // lands exactly TIMEOUT coinless PAY cycles after entry or the last coin.
    always_comb begin
        timer_d = timer_q;
        if (win_coin)
            timer_d = 8'd0;
        else if (timer_q != 8'hFF)
            timer_d = timer_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_q        <= IW'(N_KIOSK - 1);
            win_q         <= '0;
            timer_q       <= 8'd0;
            origin_q      <= 3'd0;
            dest_q        <= 3'd0;
            count_q       <= 3'd0;
            grant_q       <= '0;
            done_pulse_q  <= '0;
            reject_q      <= '0;
            busy_q        <= 1'b0;
            eng_start_q   <= 1'b0;
            eng_abort_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            change_out_q  <= 8'd0;
        end else begin
            eng_start_q   <= 1'b0;
            eng_abort_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            done_pulse_q  <= '0;
            reject_q      <= '0;
            change_out_q  <= 8'd0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        win_q    <= pick_idx;
                        last_q   <= pick_idx;
                        origin_q <= org_v[pick_idx];
                        dest_q   <= dst_v[pick_idx];
                        count_q  <= cnt_v[pick_idx];
                        grant_q  <= N_KIOSK'(1) << pick_idx;
                        busy_q   <= 1'b1;
                        if (pick_bad) begin
                            state_q            <= S_REJECT;
                            reject_q[pick_idx] <= 1'b1;
                        end else begin
                            state_q     <= S_START;
                            eng_start_q <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    timer_q <= 8'd0;
                    state_q <= S_PAY;
                end
                S_PAY: begin
                    timer_q <= timer_d;
                    if (eng_done) begin
                        state_q             <= S_FINISH;
                        done_pulse_q[win_q] <= 1'b1;
                        change_out_q        <= eng_change;
                    end else if (!req[win_q]) begin
                        state_q     <= S_ABORT;
                        eng_abort_q <= 1'b1;
                    end else if (!win_coin && timer_d == TO) begin
                        state_q       <= S_ABORT;
                        eng_abort_q   <= 1'b1;
                        timeout_err_q <= 1'b1;
                    end
                end
                S_FINISH, S_ABORT, S_REJECT: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign eng_start   = eng_start_q;
    assign eng_origin  = origin_q;
    assign eng_dest    = dest_q;
    assign eng_count   = count_q;
    assign eng_abort   = eng_abort_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign done_pulse  = done_pulse_q;
    assign change_out  = change_out_q;
    assign reject      = reject_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/sell_arbiter.md
# sell_arbiter

Round-robin arbiter and sequencer that shares one ticket-sell fare engine among `N_KIOSK` kiosk front-ends. It sits between the kiosk panels and the fare engine. It selects one requesting kiosk and latches its trip parameters. It then starts the engine, forwards only that kiosk's coins, and returns change and completion to the winner. It also aborts the transaction when the kiosk leaves or stops paying.

## Interface
- `N_KIOSK`, 4: number of kiosks; 2..8.
- `TIMEOUT`, 255: idle cycles in PAY with no coin before the arbiter aborts; 1..255.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `req` input N_KIOSK: level request per kiosk; held high until that kiosk sees `done_pulse`, `reject` or `timeout_err`.
- `req_origin` input 3*N_KIOSK: origin station per kiosk; kiosk k uses bits [3k+2:3k].
- `req_dest` input 3*N_KIOSK: destination station per kiosk.
- `req_count` input 3*N_KIOSK: ticket count per kiosk.
- `coin_valid` input N_KIOSK: one-cycle coin strobe per kiosk.
- `coin_value` input 6*N_KIOSK: coin amount per kiosk.
- `eng_done` input 1: engine reports the total is paid.
- `eng_change` input 8: engine change amount; valid together with `eng_done`.
- `eng_start` output 1: one-cycle start pulse to the engine.
- `eng_origin`, `eng_dest`, `eng_count` output 3 each: latched trip parameters; stable from START until the next grant.
- `eng_coin_valid` output 1: forwarded coin strobe.
- `eng_coin_value` output 6: forwarded coin amount.
- `eng_abort` output 1: one-cycle pulse that cancels the engine transaction.
- `grant` output N_KIOSK: one-hot current owner; zero in IDLE.
- `busy` output 1: high in every state except IDLE.
- `done_pulse` output N_KIOSK: one-cycle completion pulse to the winner.
- `change_out` output 8: change for the winner; valid with `done_pulse`, 0 otherwise.
- `reject` output N_KIOSK: one-cycle pulse for an invalid request.
- `timeout_err` output 1: one-cycle pulse when an abort is caused by timeout.

## Operation
- **State machine:** IDLE, START, PAY, FINISH, ABORT, REJECT. State is encoded in 3 bits.
- **IDLE:**
  - If `req` is non-zero, pick a winner by round robin. The search starts at `(last+1) mod N_KIOSK`.
  - Latch the winner's origin, destination and count. Set `grant`.
  - If origin equals destination or count is 0, go to REJECT. Otherwise go to START.
  - `last` takes the winner index on every grant, including rejected ones.
- **START:** drive `eng_start` = 1 for one cycle, clear the timer, then go to PAY.
- **PAY:**
  - `eng_coin_valid` = `coin_valid[winner]` and `eng_coin_value` = `coin_value[winner]`, combinationally. Coins from other kiosks are dropped.
  - The timer resets on a winner coin. Otherwise it increments, saturating at 255.
  - Exits are checked in this priority order:
    1. `eng_done` → FINISH, latching `eng_change`.
    2. `req[winner]` = 0 → ABORT, with `timeout_err` = 0.
    3. Timer equals `TIMEOUT` with no coin this cycle → ABORT, with `timeout_err` = 1.
- **FINISH:** drive `done_pulse[winner]` = 1 and `change_out` = latched change for one cycle, then go to IDLE.
- **ABORT:** drive `eng_abort` = 1 for one cycle, plus `timeout_err` if that was the cause, then go to IDLE.
- **REJECT:** drive `reject[winner]` = 1 for one cycle, then go to IDLE. The engine is not touched.
- `grant` stays held from the START or REJECT entry through the last cycle of FINISH, ABORT or REJECT. It clears in IDLE.

## Timing
- **Reset:** all outputs are 0, the state is IDLE, `last` = N_KIOSK-1 (so kiosk 0 has highest priority), the timer is 0, and latched fields are 0. Reset asserted mid-transaction returns to IDLE the next cycle. No `eng_abort` is issued; the engine shares the reset.
- **Start latency:** with `req` sampled high at edge t in IDLE, `grant` and `eng_start` are high in cycle t+1, and PAY begins at t+2.
- **Completion latency:** with `eng_done` sampled at edge t in PAY, `done_pulse` is high in cycle t+1, and IDLE begins at t+2. The earliest re-grant is at t+3.
- **Coin forwarding:** zero latency, and only in PAY. A coin strobe in START, FINISH or ABORT is not forwarded.
- **Timeout:** the abort fires exactly `TIMEOUT` coinless cycles after PAY entry or after the last coin.
- **Simultaneous events:** `eng_done` together with a request drop or timeout resolves as done. Several requests in IDLE resolve by round robin, never a fixed priority.
- **Late requests:** a `req` that rises while the block is busy is served in a later IDLE.

## Test plan
- **Single kiosk:** after reset, kiosk 2 sends origin 1, destination 4, count 2, and the engine asserts `eng_done` with change 5 after two coins. Expect `grant` = 0100 and `eng_start` one cycle later, both coins forwarded, then `done_pulse[2]` with `change_out` = 5, then `busy` = 0.
- **Fairness:** `req` is held at 1111 across four transactions. Expect winners in order 0, 1, 2, 3, then 0 again, with exactly one `grant` bit ever high.
- **Coin isolation:** while kiosk 1 owns the engine, kiosk 3 strobes 20. Expect `eng_coin_valid` to stay 0 for that coin.
- **Timeout:** with `TIMEOUT` = 10, the winner inserts no coin. Expect `eng_abort` and `timeout_err` exactly 10 cycles into PAY, with no `done_pulse`.
- **Request drop:**
  - The winner drops `req` in PAY. Expect `eng_abort` = 1 and `timeout_err` = 0.
  - The drop and `eng_done` occur in the same cycle. Expect FINISH.
- **Invalid request and reset:**
  - A request with origin equal to destination (3, 3), or with count 0, gets `reject` and never sees `eng_start`.
  - `reset` asserted in PAY returns all outputs to 0 the next cycle, and kiosk 0 wins next.
